// File: rtl/bitwise_pkg.sv
// Shared encodings for the bitwise accumulator: operation codes and FSM states.
package bitwise_pkg;

  typedef enum logic [1:0] {
    OpAnd  = 2'b00,
    OpOr   = 2'b01,
    OpXor  = 2'b10,
    OpNand = 2'b11
  } op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StFold = 1'b1
  } state_e;

endpackage

// File: rtl/bitwise_accum_if.sv
// Input beat / output result handshake bundle of the bitwise accumulator.
interface bitwise_accum_if
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
);

  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  op_e              op_i;
  logic             mode_i;
  logic             last_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] Y_o;
  logic [CNT_W-1:0] cnt_o;
  logic             ovf_o;
  logic             out_valid_o;
  logic             out_ready_i;

  modport slave (
    input  A_i, B_i, op_i, mode_i, last_i, in_valid_i, out_ready_i,
    output in_ready_o, Y_o, cnt_o, ovf_o, out_valid_o
  );

  modport master (
    output A_i, B_i, op_i, mode_i, last_i, in_valid_i, out_ready_i,
    input  in_ready_o, Y_o, cnt_o, ovf_o, out_valid_o
  );

endinterface

// File: rtl/bitwise_op.sv
// Combinational bitwise operator shared by the pairwise and fold datapaths.
module bitwise_op
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OpAnd:   y_o = a_i & b_i;
      OpOr:    y_o = a_i | b_i;
      OpXor:   y_o = a_i ^ b_i;
      OpNand:  y_o = ~(a_i & b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_accum.sv
// Bitwise accumulator: pairwise A op B, or fold-reduction of A over a burst,
// with a registered result behind a valid/ready handshake.
module bitwise_accum
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  bitwise_accum_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] beat_q;
  logic             bovf_q;
  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic             in_ready;
  logic             accept;
  op_e              op_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_y;
  logic [CNT_W-1:0] beat_d;
  logic             bovf_d;

  assign in_ready = !out_valid_q || bus.out_ready_i;
  assign accept   = bus.in_valid_i && in_ready;

  // In FOLD the operator folds the stream word into the accumulator.
  always_comb begin
    op_sel = bus.op_i;
    op_a   = bus.A_i;
    op_b   = bus.B_i;
    if (state_q == StFold) begin
      op_sel = op_q;
      op_a   = acc_q;
      op_b   = bus.A_i;
    end
  end

  bitwise_op #(
    .WIDTH(WIDTH)
  ) u_op (
    .a_i (op_a),
    .b_i (op_b),
    .op_i(op_sel),
    .y_o (op_y)
  );

  // Beat count saturates; the overflow flag remembers that it tried to pass the top.
  always_comb begin
    beat_d = beat_q;
    bovf_d = bovf_q;
    if (beat_q == CntMax) begin
      bovf_d = 1'b1;
    end else begin
      beat_d = beat_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      op_q        <= OpAnd;
      acc_q       <= '0;
      beat_q      <= '0;
      bovf_q      <= 1'b0;
      y_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        unique case (state_q)
          StIdle: begin
            if (!bus.mode_i) begin
              y_q         <= op_y;
              cnt_q       <= CNT_W'(1);
              ovf_q       <= 1'b0;
              out_valid_q <= 1'b1;
            end else if (bus.last_i) begin
              y_q         <= bus.A_i;
              cnt_q       <= CNT_W'(1);
              ovf_q       <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              acc_q   <= bus.A_i;
              op_q    <= bus.op_i;
              beat_q  <= CNT_W'(1);
              bovf_q  <= 1'b0;
              state_q <= StFold;
            end
          end
          StFold: begin
            acc_q  <= op_y;
            beat_q <= beat_d;
            bovf_q <= bovf_d;
            if (bus.last_i) begin
              y_q         <= op_y;
              cnt_q       <= beat_d;
              ovf_q       <= bovf_d;
              out_valid_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.Y_o         = y_q;
  assign bus.cnt_o       = cnt_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.out_valid_o = out_valid_q;

endmodule
